// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: owns the PC, issues in-order imem requests, buffers
// returned words with their PCs for decode, and squashes wrong-path fetches on redirect.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0100_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pcsel,
   input  logic [31:0] target_pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic        misaligned_fault
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW:0] DepthW = DEPTH[CW:0];

   typedef enum logic [0:0] {StRun, StFault} state_e;

   state_e          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]   count_q, count_d;
   logic [AW-1:0]   pcq_wr_q, pcq_wr_d;
   logic [AW-1:0]   pcq_rd_q, pcq_rd_d;
   logic [AW-1:0]   buf_head_q, buf_head_d;
   logic [AW-1:0]   buf_tail_q, buf_tail_d;

   logic [31:0]     pcq_mem  [DEPTH];
   logic [31:0]     buf_data [DEPTH];
   logic [31:0]     buf_pc   [DEPTH];

   logic [CW:0]     occupancy;
   logic            redirect;
   logic            target_misaligned;
   logic            accept;
   logic            rsp_take;
   logic            rsp_drop;
   logic            buf_we;
   logic            deq;

   // Slots in use: requests still owed a response plus words waiting for decode.
   assign occupancy = {1'b0, outstanding_q} + {1'b0, count_q};

   always_comb begin
      redirect          = pcsel && (state_q == StRun);
      target_misaligned = (target_pc[1:0] != 2'b00);
      imem_req_valid    = !reset && (state_q == StRun) && (occupancy < DepthW) && !pcsel;
      imem_req_addr     = pc_q;
      accept            = imem_req_valid && imem_req_ready;
      rsp_take          = imem_rsp_valid && (outstanding_q != '0);
      rsp_drop          = rsp_take && (drop_cnt_q != '0);
      // A response landing in the redirect cycle belongs to the old path.
      buf_we            = rsp_take && (drop_cnt_q == '0) && !redirect;
      inst_valid        = (count_q != '0);
      deq               = inst_valid && inst_ready;
      inst              = buf_data[buf_head_q];
      inst_pc           = buf_pc[buf_head_q];
      misaligned_fault  = (state_q == StFault);
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_take);
      drop_cnt_d    = drop_cnt_q - CW'(rsp_drop);
      count_d       = count_q + CW'(buf_we) - CW'(deq);
      pcq_wr_d      = accept   ? pcq_wr_q + 1'b1   : pcq_wr_q;
      pcq_rd_d      = rsp_take ? pcq_rd_q + 1'b1   : pcq_rd_q;
      buf_tail_d    = buf_we   ? buf_tail_q + 1'b1 : buf_tail_q;
      buf_head_d    = deq      ? buf_head_q + 1'b1 : buf_head_q;

      if (accept) begin
         pc_d = pc_q + 32'd4;
      end

      if (redirect) begin
         // PC queue entries stay put so the drained responses still pop them in order.
         count_d    = '0;
         buf_head_d = buf_tail_q;
         buf_tail_d = buf_tail_q;
         drop_cnt_d = outstanding_d;
         if (target_misaligned) begin
            state_d = StFault;
         end else begin
            pc_d = target_pc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StRun;
         pc_q          <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         count_q       <= '0;
         pcq_wr_q      <= '0;
         pcq_rd_q      <= '0;
         buf_head_q    <= '0;
         buf_tail_q    <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         count_q       <= count_d;
         pcq_wr_q      <= pcq_wr_d;
         pcq_rd_q      <= pcq_rd_d;
         buf_head_q    <= buf_head_d;
         buf_tail_q    <= buf_tail_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         pcq_mem[pcq_wr_q] <= pc_q;
      end
      if (buf_we) begin
         buf_data[buf_tail_q] <= imem_rsp_data;
         buf_pc[buf_tail_q]   <= pcq_mem[pcq_rd_q];
      end
   end

`ifndef SYNTHESIS
   a_buf_no_overflow: assert property (@(posedge clk) disable iff (reset)
      buf_we |-> ({1'b0, count_q} < DepthW));
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based reference model.
module tb_fetch_stage;

   localparam logic [31:0] RPC   = 32'h0100_0000;
   localparam int unsigned DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset, pcsel, imem_req_ready, imem_rsp_valid, inst_ready;
   logic [31:0] target_pc, imem_rsp_data;
   logic        imem_req_valid, inst_valid, misaligned_fault;
   logic [31:0] imem_req_addr, inst, inst_pc;
   logic        w_req_valid, w_inst_valid, w_fault;
   logic [31:0] w_req_addr, w_inst, w_inst_pc;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .pcsel(pcsel), .target_pc(target_pc),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid), .inst(inst),
      .inst_pc(inst_pc), .inst_ready(inst_ready), .misaligned_fault(misaligned_fault)
   );

   // Second instance only exercises PC wrap-around; it never gets responses.
   fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_wrap (
      .clk(clk), .reset(reset), .pcsel(1'b0), .target_pc(32'h0),
      .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
      .imem_req_ready(1'b1), .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
      .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc(w_inst_pc),
      .inst_ready(1'b1), .misaligned_fault(w_fault)
   );

   typedef struct {logic [31:0] pc; bit drop;}          flight_t;
   typedef struct {logic [31:0] data; logic [31:0] pc;} entry_t;
   typedef struct {logic [31:0] addr; int due;}         mreq_t;

   flight_t     m_fl[$];
   entry_t      m_buf[$];
   mreq_t       memq[$];
   logic [31:0] m_pc = RPC;
   bit          m_fault = 1'b0;
   bit          model_ok = 1'b0;

   int cyc = 0;
   int n_cmp = 0;
   int n_err = 0;
   int rsp_pct = 100;
   int lat_max = 0;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A3C, ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input bit r, input bit ps, input logic [31:0] tgt,
                       input bit rdy, input bit irdy);
      bit      ev, eiv;
      flight_t f;
      @(posedge clk);
      #1;
      cyc++;
      reset          = r;
      pcsel          = r ? 1'b0 : ps;
      target_pc      = tgt;
      imem_req_ready = r ? 1'b0 : rdy;
      inst_ready     = irdy;
      if (!r && memq.size() > 0 && memq[0].due <= cyc &&
          int'($urandom_range(0, 99)) < rsp_pct) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memword(memq[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      @(negedge clk);

      ev  = !r && !m_fault && (m_fl.size() + m_buf.size() < DEPTH) && !pcsel;
      eiv = (m_buf.size() > 0);
      if (model_ok) begin
         chk("req_valid", imem_req_valid, ev);
         if (ev) chk("req_addr", imem_req_addr, m_pc);
         chk("inst_valid", inst_valid, eiv);
         if (eiv) begin
            chk("inst", inst, m_buf[0].data);
            chk("inst_pc", inst_pc, m_buf[0].pc);
         end
         chk("misaligned_fault", misaligned_fault, m_fault);
      end

      // Memory: in order, at least one cycle of latency, forgets everything on reset.
      if (r) begin
         memq.delete();
      end else begin
         if (imem_rsp_valid) void'(memq.pop_front());
         if (imem_req_valid && imem_req_ready)
            memq.push_back('{addr: imem_req_addr, due: cyc + 1 + int'($urandom_range(0, lat_max))});
      end

      if (r) begin
         m_fl.delete();
         m_buf.delete();
         m_pc     = RPC;
         m_fault  = 1'b0;
         model_ok = 1'b1;
      end else if (model_ok) begin
         if (eiv && irdy) void'(m_buf.pop_front());
         if (imem_rsp_valid) begin
            chk("rsp_has_request", m_fl.size() > 0, 1);
            if (m_fl.size() > 0) begin
               f = m_fl.pop_front();
               if (!f.drop) m_buf.push_back('{data: imem_rsp_data, pc: f.pc});
            end
         end
         if (ev && imem_req_ready) begin
            m_fl.push_back('{pc: m_pc, drop: 1'b0});
            m_pc = m_pc + 32'd4;
         end
         if (pcsel && !m_fault) begin
            m_buf.delete();
            foreach (m_fl[i]) m_fl[i].drop = 1'b1;
            if (tgt[1:0] != 2'b00) m_fault = 1'b1;
            else m_pc = tgt;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      bit r, ps;
      logic [31:0] tgt;
      reset = 1'b1; pcsel = 1'b0; target_pc = '0; imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;

      // Reset and streaming with 1-cycle memory.
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1);
      chk("first_req_valid", imem_req_valid, 1);
      chk("first_req_addr", imem_req_addr, 32'h0100_0000);
      chk("wrap_addr0", w_req_addr, 32'hFFFF_FFFC);
      step(0, 0, 0, 1, 1);
      chk("second_req_addr", imem_req_addr, 32'h0100_0004);
      chk("wrap_valid1", w_req_valid, 1);
      chk("wrap_addr1", w_req_addr, 32'h0000_0000);
      step(0, 0, 0, 1, 1);
      chk("first_inst_valid", inst_valid, 1);
      chk("first_inst_pc", inst_pc, 32'h0100_0000);
      chk("first_inst", inst, memword(32'h0100_0000));
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1);

      // Decode backpressure, then release.
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1);

      // Redirect with two requests in flight.
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
      rsp_pct = 0;
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);
      chk("two_in_flight", memq.size(), 2);
      step(0, 1, 32'h0100_0040, 1, 1);
      rsp_pct = 100;
      k = 0;
      do begin
         step(0, 0, 0, 1, 1);
         k++;
      end while (!inst_valid && k < 20);
      chk("redirect_first_pc", inst_valid ? inst_pc : 32'hDEAD_DEAD, 32'h0100_0040);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);

      // Misaligned redirect, then reset recovery.
      step(0, 1, 32'h0100_0042, 1, 1);
      step(0, 0, 0, 1, 1);
      chk("fault_set", misaligned_fault, 1);
      chk("fault_no_req", imem_req_valid, 0);
      chk("fault_no_inst", inst_valid, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 32'h0100_0080, 1, 1);
      chk("fault_sticky", misaligned_fault, 1);
      step(1, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);
      chk("fault_cleared", misaligned_fault, 0);
      chk("restart_addr", imem_req_addr, 32'h0100_0000);

      // Mid-operation reset with two outstanding.
      rsp_pct = 0;
      step(0, 0, 0, 1, 1);
      step(1, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);
      chk("midreset_inst_valid", inst_valid, 0);
      chk("midreset_req_valid", imem_req_valid, 1);
      chk("midreset_addr", imem_req_addr, 32'h0100_0000);

      // Randomized traffic.
      rsp_pct = 80;
      lat_max = 2;
      for (int i = 0; i < 3000; i++) begin
         r   = m_fault ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
         ps  = ($urandom_range(0, 99) < 6);
         tgt = RPC + {24'h0, 6'($urandom_range(0, 63)), 2'b00};
         if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
         step(r, ps, tgt, $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 70);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
